// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register map,
// run/halt/timeout states and the tohost pass code.
package dmem_responder_pkg;

    localparam logic [4:0] OFF_TOHOST   = 5'h00;
    localparam logic [4:0] OFF_CONSOLE  = 5'h04;
    localparam logic [4:0] OFF_CYCLE_LO = 5'h08;
    localparam logic [4:0] OFF_CYCLE_HI = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH  = 5'h10;

    localparam logic [31:0] PASS_CODE = 32'd1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // Expand per-byte write enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] wen);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wen[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory port bundle; the core drives address/data/enables and the
// responder returns combinational read data.
interface dmem_responder_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;

    modport master (
        output d_mem_addr,
        output d_mem_wdata,
        output d_mem_wen,
        input  d_mem_rdata
    );

    modport slave (
        input  d_mem_addr,
        input  d_mem_wdata,
        input  d_mem_wen,
        output d_mem_rdata
    );
endinterface

// File: rtl/dmem_ram.sv
// Byte-enabled word RAM with asynchronous read and synchronous write; one
// byte-wide array per lane so each lane has a single writer.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder: address decode, RAM, MMIO registers (tohost, console,
// cycle counter, scratch) and the run/halted/timeout state machine.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] MMIO_BASE      = 32'h1000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_responder_if.slave        bus,
    output logic                   halted_o,
    output logic                   pass_o,
    output logic [30:0]            fail_code_o,
    output logic                   timeout_o,
    output logic                   char_valid_o,
    output logic [7:0]             char_o,
    output logic                   bad_access_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [63:0] LAST_RUN_CYCLE = 64'(TIMEOUT_CYCLES) - 64'd1;

    state_t      state_reg, state_next;
    logic [63:0] cycle_reg;
    logic [31:0] tohost_reg;
    logic [31:0] scratch_reg;
    logic [7:0]  char_reg;
    logic        char_valid_reg;
    logic        bad_access_reg;

    logic        running;
    logic        is_ram;
    logic        is_mmio;
    logic [4:0]  mmio_off;
    logic        any_wen;
    logic [31:0] wmask;
    logic        tohost_wr;
    logic        console_wr;
    logic        scratch_wr;
    logic        unmapped_wr;
    logic        timeout_hit;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] rdata;

    assign running  = (state_reg == ST_RUN);
    assign is_ram   = ({1'b0, bus.d_mem_addr} < RAM_BYTES);
    assign is_mmio  = !is_ram && (bus.d_mem_addr[31:5] == MMIO_BASE[31:5]);
    // Byte offset within the word is irrelevant; lanes come from the enables.
    assign mmio_off = {bus.d_mem_addr[4:2], 2'b00};
    assign any_wen  = (bus.d_mem_wen != 4'b0000);
    assign wmask    = byte_mask(bus.d_mem_wen);

    assign tohost_wr   = running && is_mmio && (mmio_off == OFF_TOHOST) && any_wen;
    assign console_wr  = running && is_mmio && (mmio_off == OFF_CONSOLE) && bus.d_mem_wen[0];
    assign scratch_wr  = running && is_mmio && (mmio_off == OFF_SCRATCH) && any_wen;
    assign unmapped_wr = running && !is_ram && !is_mmio && any_wen;
    assign timeout_hit = running && (cycle_reg == LAST_RUN_CYCLE);
    assign ram_we      = (running && is_ram) ? bus.d_mem_wen : 4'b0000;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.d_mem_addr[AW+1:2]),
        .wdata (bus.d_mem_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A tohost write in the final run cycle takes precedence over the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (tohost_wr) begin
                    state_next = ST_HALTED;
                end else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_HALTED:  state_next = ST_HALTED;
            ST_TIMEOUT: state_next = ST_TIMEOUT;
            default:    state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_reg      <= '0;
            tohost_reg     <= '0;
            scratch_reg    <= '0;
            char_reg       <= '0;
            char_valid_reg <= 1'b0;
            bad_access_reg <= 1'b0;
        end else begin
            if (running) begin
                cycle_reg <= cycle_reg + 64'd1;
            end
            if (tohost_wr) begin
                tohost_reg <= bus.d_mem_wdata & wmask;
            end
            if (scratch_wr) begin
                scratch_reg <= (scratch_reg & ~wmask) | (bus.d_mem_wdata & wmask);
            end
            char_valid_reg <= console_wr;
            if (console_wr) begin
                char_reg <= bus.d_mem_wdata[7:0];
            end
            if (unmapped_wr) begin
                bad_access_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram_rdata;
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_CYCLE_LO: rdata = cycle_reg[31:0];
                OFF_CYCLE_HI: rdata = cycle_reg[63:32];
                OFF_SCRATCH:  rdata = scratch_reg;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.d_mem_rdata = rdata;

    assign halted_o     = (state_reg == ST_HALTED);
    assign timeout_o    = (state_reg == ST_TIMEOUT);
    assign pass_o       = halted_o && (tohost_reg == PASS_CODE);
    assign fail_code_o  = (halted_o && (tohost_reg != PASS_CODE)) ? tohost_reg[31:1] : '0;
    assign char_valid_o = char_valid_reg;
    assign char_o       = char_reg;
    assign bad_access_o = bad_access_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan steps plus random bus traffic checked
// against a behavioural memory/MMIO model.
module tb_dmem_responder;

    localparam int unsigned DEPTH     = 1024;
    localparam logic [31:0] MMIO      = 32'h1000_0000;
    localparam int unsigned TO_A      = 20000;
    localparam int unsigned TO_B      = 16;
    localparam int          PRE_WORDS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    logic        halted_a, pass_a, timeout_a, cv_a, bad_a;
    logic [30:0] fc_a;
    logic [7:0]  ch_a;
    logic        halted_b, pass_b, timeout_b, cv_b, bad_b;
    logic [30:0] fc_b;
    logic [7:0]  ch_b;

    dmem_responder #(
        .DEPTH_WORDS    (DEPTH),
        .MMIO_BASE      (MMIO),
        .TIMEOUT_CYCLES (TO_A)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n_a),
        .bus          (bus_a),
        .halted_o     (halted_a),
        .pass_o       (pass_a),
        .fail_code_o  (fc_a),
        .timeout_o    (timeout_a),
        .char_valid_o (cv_a),
        .char_o       (ch_a),
        .bad_access_o (bad_a)
    );

    dmem_responder #(
        .DEPTH_WORDS    (DEPTH),
        .MMIO_BASE      (MMIO),
        .TIMEOUT_CYCLES (TO_B)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n_b),
        .bus          (bus_b),
        .halted_o     (halted_b),
        .pass_o       (pass_b),
        .fail_code_o  (fc_b),
        .timeout_o    (timeout_b),
        .char_valid_o (cv_b),
        .char_o       (ch_b),
        .bad_access_o (bad_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of dut_a
    logic [31:0] ram_m [PRE_WORDS];
    logic [31:0] scratch_m, tohost_m;
    logic [63:0] cyc_m;
    logic        halt_m, to_m, bad_m, cv_m;
    logic [7:0]  ch_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) return ram_m[int'(a >> 2) % PRE_WORDS];
        if (a[31:5] == MMIO[31:5]) begin
            case (a[4:2])
                3'd2:    return cyc_m[31:0];
                3'd3:    return cyc_m[63:32];
                3'd4:    return scratch_m;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // Advance the model by one clock edge using the inputs currently on bus_a.
    task automatic model_edge_a();
        logic [31:0] a, d, m;
        logic [3:0]  w;
        logic        th;
        int          idx;
        a = bus_a.d_mem_addr;
        d = bus_a.d_mem_wdata;
        w = bus_a.d_mem_wen;
        m = '0;
        for (int i = 0; i < 4; i++) if (w[i]) m[8*i +: 8] = 8'hFF;
        th   = 1'b0;
        cv_m = 1'b0;
        if (!halt_m && !to_m) begin
            if (a < 32'(DEPTH * 4)) begin
                idx = int'(a >> 2);
                if (idx < PRE_WORDS) ram_m[idx] = (ram_m[idx] & ~m) | (d & m);
            end else if (a[31:5] == MMIO[31:5]) begin
                case (a[4:2])
                    3'd0: if (w != 4'd0) begin th = 1'b1; tohost_m = d & m; end
                    3'd1: if (w[0]) begin ch_m = d[7:0]; cv_m = 1'b1; end
                    3'd4: scratch_m = (scratch_m & ~m) | (d & m);
                    default: ;
                endcase
            end else if (w != 4'd0) begin
                bad_m = 1'b1;
            end
            if (th) halt_m = 1'b1;
            else if (cyc_m == 64'(TO_A - 1)) to_m = 1'b1;
            cyc_m = cyc_m + 64'd1;
        end
    endtask

    task automatic cycle_a();
        model_edge_a();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle_b();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs_a(input string tag);
        check({tag, ".halted"},  64'(halted_a),  64'(halt_m));
        check({tag, ".pass"},    64'(pass_a),    64'(halt_m && tohost_m == 32'd1));
        check({tag, ".fail"},    64'(fc_a),
              64'((halt_m && tohost_m != 32'd1) ? (tohost_m >> 1) : 32'd0));
        check({tag, ".timeout"}, 64'(timeout_a), 64'(to_m));
        check({tag, ".cvalid"},  64'(cv_a),      64'(cv_m));
        check({tag, ".char"},    64'(ch_a),      64'(ch_m));
        check({tag, ".bad"},     64'(bad_a),     64'(bad_m));
    endtask

    // One bus transaction on dut_a: check read data, clock it, check outputs.
    task automatic op_a(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
        bus_a.d_mem_addr  = a;
        bus_a.d_mem_wdata = d;
        bus_a.d_mem_wen   = w;
        #1;
        check({tag, ".rdata"}, 64'(bus_a.d_mem_rdata), 64'(model_read(a)));
        $display("[TB] %s addr=%h wdata=%h wen=%b rdata=%h", tag, a, d, w, bus_a.d_mem_rdata);
        cycle_a();
        bus_a.d_mem_wen = 4'd0;
        check_outs_a(tag);
    endtask

    task automatic read_const_a(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_a.d_mem_addr = a;
        bus_a.d_mem_wen  = 4'd0;
        #1;
        check(tag, 64'(bus_a.d_mem_rdata), 64'(exp));
    endtask

    task automatic reset_a();
        rst_n_a         = 1'b0;
        bus_a.d_mem_wen = 4'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n_a   = 1'b1;
        halt_m    = 1'b0;
        to_m      = 1'b0;
        bad_m     = 1'b0;
        cv_m      = 1'b0;
        ch_m      = 8'd0;
        cyc_m     = 64'd0;
        tohost_m  = 32'd0;
        scratch_m = 32'd0;
    endtask

    task automatic reset_b();
        rst_n_b         = 1'b0;
        bus_b.d_mem_wen = 4'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n_b = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd;
        logic [3:0]  rw;
        int          kind;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.d_mem_addr = '0; bus_a.d_mem_wdata = '0; bus_a.d_mem_wen = '0;
        bus_b.d_mem_addr = '0; bus_b.d_mem_wdata = '0; bus_b.d_mem_wen = '0;
        @(negedge clk);
        reset_b();
        reset_a();

        // Reset state
        check_outs_a("reset");
        read_const_a("reset.cycle_lo", MMIO + 32'h8, 32'd0);
        read_const_a("reset.scratch", MMIO + 32'h10, 32'd0);

        // Preload RAM through the bus
        for (int i = 0; i < PRE_WORDS; i++) begin
            rd = (i == 5) ? 32'hAABB_CCDD : $urandom;
            op_a("preload", 32'(i * 4), rd, 4'hF);
        end

        // Single-lane store into a preloaded word
        op_a("lane_wr", 32'h14, 32'h0000_1100, 4'b0010);
        read_const_a("lane_wr.result", 32'h14, 32'hAABB_11DD);

        // Scratch byte-enabled writes
        op_a("scr_full", MMIO + 32'h10, 32'h1234_5678, 4'b1111);
        op_a("scr_top", MMIO + 32'h10, 32'hFF00_0000, 4'b1000);
        read_const_a("scr.result", MMIO + 32'h10, 32'hFF34_5678);

        // Console pulse, then an unmapped write
        op_a("console", MMIO + 32'h4, 32'h0000_0041, 4'b0001);
        check("console.cvalid_hi", 64'(cv_a), 64'd1);
        check("console.char", 64'(ch_a), 64'h41);
        op_a("unmapped", 32'h2000_0000, 32'hDEAD_BEEF, 4'b1111);
        check("console.cvalid_lo", 64'(cv_a), 64'd0);
        check("unmapped.bad", 64'(bad_a), 64'd1);
        for (int i = 0; i < 3; i++) op_a("bad_hold", 32'h14, 32'd0, 4'd0);

        // Mid-run reset: outputs clear, RAM kept
        reset_a();
        check_outs_a("rst_mid");
        check("rst_mid.bad", 64'(bad_a), 64'd0);
        read_const_a("rst_mid.ram5", 32'h14, 32'hAABB_11DD);

        // Random traffic (no tohost writes)
        for (int k = 0; k < 400; k++) begin
            kind = int'($urandom_range(0, 7));
            rd   = $urandom;
            rw   = 4'd0;
            case (kind)
                0: begin ra = 32'($urandom_range(0, PRE_WORDS * 4 - 1)); rw = 4'($urandom_range(1, 15)); end
                1: ra = 32'($urandom_range(0, PRE_WORDS * 4 - 1));
                2: ra = MMIO + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
                3: begin ra = MMIO + 32'h10 + 32'($urandom_range(0, 3)); rw = 4'($urandom_range(0, 15)); end
                4: begin ra = MMIO + 32'h4; rw = 4'($urandom_range(0, 15)); end
                5: begin ra = 32'h2000_0000 + ($urandom & 32'h0000_FFFC); rw = 4'($urandom_range(0, 15)); end
                6: begin ra = MMIO + 32'($urandom_range(5, 7) << 2); rw = 4'($urandom_range(1, 15)); end
                default: begin ra = MMIO + 32'h8 + 32'($urandom_range(0, 1) << 2); rw = 4'($urandom_range(1, 15)); end
            endcase
            op_a("rand", ra, rd, rw);
        end

        // Pass: tohost = 1, then everything frozen
        reset_a();
        op_a("pass", MMIO, 32'd1, 4'hF);
        check("pass.halted", 64'(halted_a), 64'd1);
        check("pass.pass", 64'(pass_a), 64'd1);
        check("pass.fail", 64'(fc_a), 64'd0);
        op_a("pass.ram_wr", 32'h0, 32'h5A5A_5A5A, 4'hF);
        op_a("pass.scr_wr", MMIO + 32'h10, 32'h5A5A_5A5A, 4'hF);
        op_a("pass.unmapped", 32'h3000_0000, 32'd1, 4'hF);
        for (int i = 0; i < 4; i++) op_a("pass.cyc_lo", MMIO + 32'h8, 32'd0, 4'd0);

        // Fail code: tohost = 7
        reset_a();
        op_a("fail", MMIO, 32'h0000_0007, 4'hF);
        check("fail.code", 64'(fc_a), 64'd3);
        check("fail.pass", 64'(pass_a), 64'd0);
        reset_a();
        check_outs_a("rst_halt");

        // Timeout instance: no tohost
        reset_b();
        repeat (15) cycle_b();
        check("to.before", 64'(timeout_b), 64'd0);
        cycle_b();
        check("to.at16", 64'(timeout_b), 64'd1);
        check("to.halted", 64'(halted_b), 64'd0);
        bus_b.d_mem_addr = MMIO + 32'h8;
        #1;
        check("to.cycle_lo", 64'(bus_b.d_mem_rdata), 64'd16);
        repeat (3) cycle_b();
        check("to.cycle_frozen", 64'(bus_b.d_mem_rdata), 64'd16);
        check("to.hold", 64'(timeout_b), 64'd1);
        $display("[TB] timeout run: timeout=%b halted=%b", timeout_b, halted_b);

        // Tohost in the last run cycle beats the timeout
        reset_b();
        repeat (15) cycle_b();
        bus_b.d_mem_addr  = MMIO;
        bus_b.d_mem_wdata = 32'd1;
        bus_b.d_mem_wen   = 4'hF;
        cycle_b();
        bus_b.d_mem_wen = 4'd0;
        check("race.halted", 64'(halted_b), 64'd1);
        check("race.timeout", 64'(timeout_b), 64'd0);
        check("race.pass", 64'(pass_b), 64'd1);
        repeat (3) cycle_b();
        check("race.timeout_later", 64'(timeout_b), 64'd0);
        $display("[TB] race run: timeout=%b halted=%b", timeout_b, halted_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
